// File: rtl/wb_master_bridge.sv
// Wishbone B4 classic single-transaction initiator behind a valid/ready command/response port.
// Optional bus watchdog enabled by defining WBM_TIMEOUT_EN.
module wb_master_bridge #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [31:0]          cmd_addr_i,
    input  logic [WIDTH-1:0]     cmd_wdata_i,
    input  logic [WIDTH/8-1:0]   cmd_sel_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [WIDTH-1:0]     rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 rsp_timeout_o,
    output logic [31:0]          adr_o,
    output logic [WIDTH-1:0]     dat_o,
    output logic [WIDTH/8-1:0]   sel_o,
    output logic                 we_o,
    output logic                 cyc_o,
    output logic                 stb_o,
    input  logic [WIDTH-1:0]     dat_i,
    input  logic                 ack_i,
    input  logic                 err_i
);
    localparam int          SW         = WIDTH / 8;
    localparam logic [31:0] ALIGN_MASK = 32'(SW - 1);

    if (TIMEOUT < 2 || WIDTH < 8 || (WIDTH % 8) != 0) begin : g_param_check
        $error("wb_master_bridge: illegal WIDTH/TIMEOUT");
    end

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t             state_q, state_d;
    logic               cyc_q, cyc_d;
    logic               we_q, we_d;
    logic [31:0]        adr_q, adr_d;
    logic [WIDTH-1:0]   dat_q, dat_d;
    logic [SW-1:0]      sel_q, sel_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic               rsp_to_q, rsp_to_d;
    logic [WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic               misaligned;

`ifdef WBM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    assign misaligned  = |(cmd_addr_i & ALIGN_MASK);
    assign cmd_ready_o = (state_q == IDLE) && !rst_i;

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef WBM_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    adr_d = cmd_addr_i;
                    dat_d = cmd_wdata_i;
                    sel_d = cmd_sel_i;
                    if (misaligned) begin
                        // Refused locally: no bus cycle is ever started.
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_to_d    = 1'b0;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d = BUS;
                        cyc_d   = 1'b1;
                        we_d    = cmd_we_i;
`ifdef WBM_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end
                end
            end
            BUS: begin
                if (err_i || ack_i) begin
                    state_d     = RESP;
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_to_d    = 1'b0;
                    // err wins over a simultaneous ack
                    rsp_err_d   = err_i;
                    rsp_rdata_d = (err_i || we_q) ? '0 : dat_i;
                end
`ifdef WBM_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d     = RESP;
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_to_d    = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef WBM_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef WBM_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign cyc_o         = cyc_q;
    assign stb_o         = cyc_q;
    assign we_o          = we_q;
    assign adr_o         = adr_q;
    assign dat_o         = dat_q;
    assign sel_o         = sel_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_rdata_o   = rsp_rdata_q;
`ifdef WBM_TIMEOUT_EN
    assign rsp_timeout_o = rsp_to_q;
`else
    assign rsp_timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge: vector table through a memory-model slave plus
// hand sequences for reset, stray acks and the watchdog / indefinite wait.
module tb_wb_master_bridge;
    localparam int TMO = 8;
    localparam logic [31:0] JUNK = 32'hA5A5_5A5A;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0, cmd_ready_o, cmd_we_i = 1'b0;
    logic [31:0] cmd_addr_i = '0, cmd_wdata_i = '0;
    logic [3:0]  cmd_sel_i = '0;
    logic        rsp_valid_o, rsp_ready_i = 1'b0, rsp_err_o, rsp_timeout_o;
    logic [31:0] rsp_rdata_o, adr_o, dat_o, dat_i = JUNK;
    logic [3:0]  sel_o;
    logic        we_o, cyc_o, stb_o, ack_i, err_i;
    logic        slv_ack = 1'b0, slv_err = 1'b0, stray_ack = 1'b0, stray_err = 1'b0;

    assign ack_i = slv_ack | stray_ack;
    assign err_i = slv_err | stray_err;

    always #5 clk = ~clk;

    wb_master_bridge #(.WIDTH(32), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_sel_i(cmd_sel_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
        .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .we_o(we_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
    );

    // Memory slave: acks so that cyc stays high for blen cycles; can error or stay mute.
    logic [31:0] mem [0:63] = '{default: 32'h0};
    int   blen = 2;
    int   scnt = 0;
    logic ierr = 1'b0, iack = 1'b0, mute = 1'b0;

    always @(posedge clk) begin
        slv_ack <= 1'b0;
        slv_err <= 1'b0;
        if (rst_i) begin
            scnt <= 0;
        end else if (cyc_o && stb_o && !ack_i && !err_i) begin
            scnt <= scnt + 1;
            if (!mute && scnt >= blen - 2) begin
                scnt <= 0;
                if (ierr) begin
                    slv_err <= 1'b1;
                    slv_ack <= iack;
                    dat_i   <= JUNK;
                end else begin
                    slv_ack <= 1'b1;
                    if (we_o) begin
                        for (int b = 0; b < 4; b++)
                            if (sel_o[b]) mem[adr_o[7:2]][8*b +: 8] <= dat_o[8*b +: 8];
                        dat_i <= JUNK;
                    end else begin
                        dat_i <= mem[adr_o[7:2]];
                    end
                end
            end
        end else begin
            scnt <= 0;
        end
    end

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one command, follow it to its response, hold the response 'hold' cycles
    // (optionally poking stray ack/err meanwhile) and then consume it.
    task automatic do_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] sel, input int hold, input logic poke,
                          output int ncyc, output int lat, output logic err, output logic to,
                          output logic [31:0] rd, output logic stab_ok, output logic hold_ok);
        int guard = 0;
        ncyc = 0; lat = -1; err = 1'bx; to = 1'bx; rd = 'x; stab_ok = 1'b1; hold_ok = 1'b1;
        @(negedge clk);
        while (!cmd_ready_o && guard < 50) begin @(negedge clk); guard++; end
        cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_wdata_i = wd; cmd_sel_i = sel;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0; cmd_we_i = ~we; cmd_addr_i = ~addr; cmd_wdata_i = ~wd; cmd_sel_i = ~sel;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (cyc_o) begin
                ncyc++;
                if (!stb_o || adr_o !== addr || we_o !== we || sel_o !== sel ||
                    dat_o !== wd || cmd_ready_o) stab_ok = 1'b0;
            end
            if (rsp_valid_o) begin lat = k; break; end
        end
        if (lat < 0) return;
        err = rsp_err_o; to = rsp_timeout_o; rd = rsp_rdata_o;
        for (int h = 0; h < hold; h++) begin
            if (poke) begin stray_ack = 1'b1; stray_err = 1'b1; end
            @(negedge clk);
            stray_ack = 1'b0; stray_err = 1'b0;
            if (!rsp_valid_o || rsp_err_o !== err || rsp_timeout_o !== to ||
                rsp_rdata_o !== rd || cyc_o || cmd_ready_o) hold_ok = 1'b0;
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        if (rsp_valid_o || !cmd_ready_o || cyc_o) hold_ok = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  sel;
        int          blen;
        logic        ierr;
        logic        iack;
        int          hold;
        logic        eerr;
        logic [31:0] erd;
        int          ecyc;
        int          elat;
    } vec_t;

    vec_t vecs[14];

    int ncyc, lat;
    logic err, to, stab_ok, hold_ok, stuck_ok, got;
    logic [31:0] rd;

    initial begin
        //          we    addr    wdata          sel   bl er ak hd eerr erd           cyc lat
        vecs[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2, 0, 0, 0, 1'b0, 32'h0,        2, 3};
        vecs[1]  = '{1'b0, 32'h10, 32'h0,        4'hF, 2, 0, 0, 0, 1'b0, 32'hDEADBEEF, 2, 3};
        vecs[2]  = '{1'b1, 32'h14, 32'h12345678, 4'h3, 3, 0, 0, 0, 1'b0, 32'h0,        3, 4};
        vecs[3]  = '{1'b0, 32'h14, 32'h0,        4'hF, 2, 0, 0, 0, 1'b0, 32'h00005678, 2, 3};
        vecs[4]  = '{1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 6, 0, 0, 0, 1'b0, 32'h0,        6, 7};
        vecs[5]  = '{1'b0, 32'h30, 32'h0,        4'hF, 6, 0, 0, 0, 1'b0, 32'hCAFEF00D, 6, 7};
        vecs[6]  = '{1'b0, 32'h20, 32'h0,        4'hF, 2, 1, 0, 0, 1'b1, 32'h0,        2, 3};
        vecs[7]  = '{1'b0, 32'h10, 32'h0,        4'hF, 2, 1, 1, 3, 1'b1, 32'h0,        2, 3};
        vecs[8]  = '{1'b1, 32'h24, 32'h11111111, 4'hF, 2, 1, 0, 0, 1'b1, 32'h0,        2, 3};
        vecs[9]  = '{1'b0, 32'h24, 32'h0,        4'hF, 2, 0, 0, 0, 1'b0, 32'h0,        2, 3};
        vecs[10] = '{1'b0, 32'h13, 32'h0,        4'hF, 2, 0, 0, 0, 1'b1, 32'h0,        0, 1};
        vecs[11] = '{1'b1, 32'h02, 32'h55555555, 4'hF, 2, 0, 0, 0, 1'b1, 32'h0,        0, 1};
        vecs[12] = '{1'b1, 32'h14, 32'hAABBCCDD, 4'hC, 2, 0, 0, 0, 1'b0, 32'h0,        2, 3};
        vecs[13] = '{1'b0, 32'h14, 32'h0,        4'hF, 2, 0, 0, 0, 1'b0, 32'hAABB5678, 2, 3};

        // reset state
        repeat (2) @(negedge clk);
        chk("ready in reset", 32'(cmd_ready_o), 0);
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst ready", 32'(cmd_ready_o), 1);
        chk("rst cyc/stb/we", {29'h0, cyc_o, stb_o, we_o}, 0);
        chk("rst rsp flags", {29'h0, rsp_valid_o, rsp_err_o, rsp_timeout_o}, 0);
        chk("rst adr", adr_o, 0);
        chk("rst dat", dat_o, 0);
        chk("rst sel", 32'(sel_o), 0);
        chk("rst rdata", rsp_rdata_o, 0);

        // stray ack/err while idle
        stray_ack = 1'b1; stray_err = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0; stray_err = 1'b0;
        chk("idle stray ack", {29'h0, rsp_valid_o, cyc_o, cmd_ready_o}, 32'h1);

        for (int i = 0; i < 14; i++) begin
            blen = vecs[i].blen; ierr = vecs[i].ierr; iack = vecs[i].iack;
            do_cmd(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].sel, vecs[i].hold, 1'b0,
                   ncyc, lat, err, to, rd, stab_ok, hold_ok);
            chk($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].elat));
            chk($sformatf("v%0d cyc cycles", i), 32'(ncyc), 32'(vecs[i].ecyc));
            chk($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].eerr));
            chk($sformatf("v%0d timeout", i), 32'(to), 0);
            chk($sformatf("v%0d rdata", i), rd, vecs[i].erd);
            chk($sformatf("v%0d bus stable", i), 32'(stab_ok), 1);
            chk($sformatf("v%0d rsp hold", i), 32'(hold_ok), 1);
        end
        blen = 2; ierr = 1'b0; iack = 1'b0;

        // reset during BUS abandons the cycle
        mute = 1'b1;
        @(negedge clk);
        cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 32'h40; cmd_sel_i = 4'hF;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        @(negedge clk);
        chk("pre-reset cyc", 32'(cyc_o), 1);
        rst_i = 1'b1;
        @(negedge clk);
        chk("mid rst cyc/stb/valid", {29'h0, cyc_o, stb_o, rsp_valid_o}, 0);
        chk("mid rst adr", adr_o, 0);
        rst_i = 1'b0; mute = 1'b0;
        do_cmd(1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0, ncyc, lat, err, to, rd, stab_ok, hold_ok);
        chk("post rst latency", 32'(lat), 3);
        chk("post rst rdata", rd, 32'hDEADBEEF);
        chk("post rst err", 32'(err), 0);

`ifdef WBM_TIMEOUT_EN
        // silent slave: watchdog fires, late ack/err in RESP ignored
        mute = 1'b1;
        do_cmd(1'b0, 32'h40, 32'h0, 4'hF, 2, 1'b1, ncyc, lat, err, to, rd, stab_ok, hold_ok);
        mute = 1'b0;
        chk("tmo cyc cycles", 32'(ncyc), TMO);
        chk("tmo latency", 32'(lat), TMO + 1);
        chk("tmo err", 32'(err), 1);
        chk("tmo flag", 32'(to), 1);
        chk("tmo rdata", rd, 0);
        chk("tmo late ack ignored", 32'(hold_ok), 1);
`else
        // silent slave: bridge waits, then completes when the slave finally acks
        mute = 1'b1;
        @(negedge clk);
        cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 32'h30; cmd_sel_i = 4'hF;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        stuck_ok = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (!cyc_o || rsp_valid_o || rsp_timeout_o) stuck_ok = 1'b0;
        end
        chk("wait indefinitely", 32'(stuck_ok), 1);
        mute = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid_o) begin got = 1'b1; break; end
        end
        chk("late rsp valid", 32'(got), 1);
        chk("late rsp rdata", rsp_rdata_o, 32'hCAFEF00D);
        chk("late rsp err/to", {30'h0, rsp_err_o, rsp_timeout_o}, 0);
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/wb_master_bridge.md
Name: wb_master_bridge

Overview:
- Wishbone B4 classic-cycle initiator (master) that turns a simple valid/ready command/response port into single Wishbone read/write transactions.
- Drives the slave side of sp_memory's Wishbone wrapper, or any WB B4 slave, from DMA engines, test sequencers or CPU shims.
- Single outstanding transaction; no pipelined mode, no bursts.

Parameters:
- WIDTH, 32, data bus width in bits; multiple of 8, ≥8.
- TIMEOUT, 256, bus-cycle watchdog limit in clocks; ≥2; used only with WBM_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous active-high reset
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_we_i  in  1  1=write, 0=read
- cmd_addr_i  in  32  byte address
- cmd_wdata_i  in  WIDTH  write data
- cmd_sel_i  in  WIDTH/8  byte lane enables
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_rdata_o  out  WIDTH  read data (0 for writes/errors)
- rsp_err_o  out  1  transaction ended in error
- rsp_timeout_o  out  1  error was watchdog timeout
- adr_o  out  32  WB address
- dat_o  out  WIDTH  WB write data
- sel_o  out  WIDTH/8  WB byte select
- we_o  out  1  WB write enable
- cyc_o  out  1  WB cycle
- stb_o  out  1  WB strobe
- dat_i  in  WIDTH  WB read data
- ack_i  in  1  WB acknowledge
- err_i  in  1  WB error

Behaviour:
- Reset: state IDLE; cyc_o, stb_o, we_o, rsp_valid_o, rsp_err_o, rsp_timeout_o = 0; adr_o, dat_o, sel_o, rsp_rdata_o = 0; cmd_ready_o = 1 from the first cycle after reset.
- FSM states: IDLE, BUS, RESP. All outputs are registered except cmd_ready_o, which equals (state==IDLE && !rst_i).
- IDLE, on valid&ready:
  - Latch we, addr, wdata, sel.
  - If addr[log2(WIDTH/8)-1:0] != 0 (misaligned): no bus cycle. Go to RESP with rsp_err_o=1, rsp_timeout_o=0, rsp_rdata_o=0.
  - Otherwise go to BUS with cyc_o=stb_o=1 and adr_o/dat_o/sel_o/we_o driven from the latch.
- BUS:
  - adr_o, dat_o, sel_o, we_o, cyc_o and stb_o are held stable until ack_i or err_i is sampled high.
  - ack_i only: go to RESP; rsp_err_o=0; rsp_rdata_o=dat_i for reads, 0 for writes.
  - err_i (with or without ack_i): err wins. Go to RESP; rsp_err_o=1; rsp_rdata_o=0.
  - On exit, cyc_o and stb_o are 0 in the next cycle and we_o returns to 0.
- RESP: rsp_valid_o=1 and rsp_* are held stable until rsp_ready_i. On the handshake, go to IDLE and drop rsp_valid_o next cycle.
- Latency:
  - Command accepted at edge N, so cyc_o/stb_o are high in cycle N+1.
  - With a single-cycle-ack slave, ack_i is high in N+2 and rsp_valid_o is high in N+3.
  - Minimum command-to-command spacing is 4 cycles when rsp_ready_i is tied 1.
- ack_i/err_i while not in BUS: ignored, no state change.
- rst_i mid-transaction: next edge forces the reset values. cyc_o drops immediately (abandoned cycle); any pending response is discarded.
- cmd_* inputs are sampled only on the accept edge; later changes have no effect.

Optional Feature:
- Macro: WBM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUS and increments each BUS cycle.
  - If TIMEOUT cycles pass in BUS without ack_i/err_i, cyc_o/stb_o drop next cycle and the FSM goes to RESP with rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
  - If ack/err arrives in the same cycle the limit is hit, ack/err wins.
- Undefined: no counter; the FSM waits in BUS indefinitely; rsp_timeout_o is tied 0.

Test Plan:
- Write then read: write addr 0x10, wdata 0xDEADBEEF, sel 0xF, with a 1-cycle-ack memory slave.
  - Write: cyc_o high exactly 2 cycles, rsp_err_o=0.
  - Read of 0x10: rsp_rdata_o=0xDEADBEEF at N+3.
- Slave inserts 5 wait states:
  - adr_o, we_o, sel_o, dat_o stable for all 6 BUS cycles.
  - No second strobe; cmd_ready_o=0 throughout.
- Misaligned addr 0x13:
  - cyc_o never asserts.
  - rsp_valid_o the cycle after accept with rsp_err_o=1, rsp_timeout_o=0.
- err_i and ack_i together on a read:
  - rsp_err_o=1, rsp_rdata_o=0.
  - rsp_valid_o held 3 cycles while rsp_ready_i=0, then cleared.
- rst_i asserted during BUS:
  - cyc_o=stb_o=0 and rsp_valid_o=0 after the edge.
  - A following read of 0x10 completes normally.
- WBM_TIMEOUT_EN, TIMEOUT=8, slave never acks:
  - cyc_o drops after 8 BUS cycles.
  - rsp_err_o=1, rsp_timeout_o=1.
  - A late ack_i is ignored.
